// File: rtl/video_line_fetch_arbiter.sv
// video_line_fetch_arbiter: per-line prefetch from a shared single-port frame RAM
// into a ping-pong line buffer. The RAM port is shared with a write requester.
// Fetch has priority, but a pending write gets a slot after at most MAX_BURST reads.
// Optional build macro VIDEO_FETCH_STATS_EN adds the stat_overruns and
// stat_wr_wait_max counters and their ports.
module video_line_fetch_arbiter #(
    parameter int LINE_WIDTH   = 400,
    parameter int NUM_LINES    = 360,
    parameter int DATA_W       = 24,
    parameter int ADDR_W       = $clog2(LINE_WIDTH * NUM_LINES),
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 16,
    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1,
    localparam int YW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic              line_valid,
    input  logic [YW-1:0]     line_y,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [XW:0]       lb_addr,
    output logic [DATA_W-1:0] lb_data,
    output logic              lb_rd_bank,
    output logic              fetch_done,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef VIDEO_FETCH_STATS_EN
    ,
    output logic [15:0]       stat_overruns,
    output logic [15:0]       stat_wr_wait_max
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FETCH, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [YW-1:0]     r_line_y;
    logic [ADDR_W-1:0] r_base;
    logic [XW-1:0]     r_x;
    logic [BW-1:0]     r_burst;
    logic              r_bank;
    logic              r_fetch_done;
    logic              r_overrun;
    logic              r_pv    [READ_LATENCY];
    logic              r_pbank [READ_LATENCY];
    logic [XW-1:0]     r_px    [READ_LATENCY];

    logic w_rd;
    logic w_wr;
    logic w_ls_act;
    logic w_ovr_evt;
    logic w_slot;
    logic w_x_last;
    logic w_pipe_busy;

    // A line start acts when it requests a fetch, or when it aborts one in flight
    assign w_ls_act  = line_start && (line_valid || !r_fetch_done);
    assign w_ovr_evt = line_start && !r_fetch_done;
    assign w_slot    = wr_req && (r_burst == BW'(MAX_BURST));
    assign w_x_last  = (r_x == XW'(LINE_WIDTH - 1));

    // Reads still in flight that will not be retired by this cycle's line-buffer write
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            w_pipe_busy = w_pipe_busy | r_pv[i];
        end
    end

    // Next state and RAM port arbitration; line-start actions pre-empt any grant
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ls_act) w_state_nxt = S_SETUP;
                else          w_wr = wr_req;
            end
            S_SETUP: begin
                w_state_nxt = S_FETCH;
                if (!w_ls_act) w_wr = wr_req;
            end
            S_FETCH: begin
                if (!w_ls_act) begin
                    if (w_slot) begin
                        w_wr = 1'b1;
                    end else begin
                        w_rd = 1'b1;
                        if (w_x_last) w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_ls_act) begin
                    w_wr = wr_req;
                    if (!w_pipe_busy) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_ovr_evt) w_state_nxt = line_valid ? S_SETUP : S_IDLE;
    end

    // Control state: FSM, fetch position, burst counter, bank, status flags, pipe valids
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_burst      <= '0;
            r_bank       <= 1'b0;
            r_fetch_done <= 1'b1;
            r_overrun    <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) r_pv[i] <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_ls_act && line_valid) begin
                r_bank       <= ~r_bank;
                r_fetch_done <= 1'b0;
            end else if (w_ovr_evt) begin
                r_fetch_done <= 1'b1;
            end else if (r_state == S_DRAIN && !w_pipe_busy) begin
                r_fetch_done <= 1'b1;
            end

            if (r_state == S_SETUP)     r_x <= '0;
            else if (w_rd && !w_x_last) r_x <= r_x + XW'(1);

            if (!wr_req || w_wr) r_burst <= '0;
            else if (w_rd)       r_burst <= r_burst + BW'(1);

            if (w_ovr_evt)        r_overrun <= 1'b1;
            else if (overrun_clr) r_overrun <= 1'b0;

            r_pv[0] <= w_rd && !w_ovr_evt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1] && !w_ovr_evt;
            end
        end
    end

    // Datapath: latched line index, line base address, and the tag pipe that follows each read
    always_ff @(posedge clk) begin
        if (w_ls_act && line_valid) r_line_y <= line_y;
        if (r_state == S_SETUP)     r_base   <= ADDR_W'(r_line_y) * ADDR_W'(LINE_WIDTH);
        r_pbank[0] <= ~r_bank;
        r_px[0]    <= r_x;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_pbank[i] <= r_pbank[i-1];
            r_px[i]    <= r_px[i-1];
        end
    end

    assign mem_rd     = w_rd;
    assign mem_wr     = w_wr;
    assign wr_ack     = w_wr;
    assign mem_addr   = w_rd ? (r_base + ADDR_W'(r_x)) : (w_wr ? wr_addr : '0);
    assign mem_wdata  = w_wr ? wr_data : '0;
    assign lb_we      = r_pv[READ_LATENCY-1] && !w_ovr_evt;
    assign lb_addr    = {r_pbank[READ_LATENCY-1], r_px[READ_LATENCY-1]};
    assign lb_data    = mem_rdata;
    assign lb_rd_bank = r_bank;
    assign fetch_done = r_fetch_done;
    assign overrun    = r_overrun;

`ifdef VIDEO_FETCH_STATS_EN
    logic [15:0] r_stat_ovr;
    logic [15:0] r_wait;
    logic [15:0] r_wait_max;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating overrun count, current write wait and longest write wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_ovr <= '0;
            r_wait     <= '0;
            r_wait_max <= '0;
        end else begin
            if (w_ovr_evt) r_stat_ovr <= sat_inc(r_stat_ovr);
            if (wr_req && !w_wr) r_wait <= sat_inc(r_wait);
            else                 r_wait <= '0;
            if (w_wr && (r_wait > r_wait_max)) r_wait_max <= r_wait;
        end
    end

    assign stat_overruns    = r_stat_ovr;
    assign stat_wr_wait_max = r_wait_max;
`endif

endmodule

// File: tb/tb_video_line_fetch_arbiter.sv
// Bench for video_line_fetch_arbiter: table of line fetches plus hand-written
// sequences for idle write, overrun and asynchronous reset. Line-buffer writes
// are checked against a scoreboard queue filled when each line start is driven.
module tb_video_line_fetch_arbiter;

    localparam int LW  = 8;
    localparam int NL  = 16;
    localparam int DW  = 24;
    localparam int AW  = 7;
    localparam int RL  = 2;
    localparam int MB  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start, line_valid;
    logic [3:0]    line_y;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          lb_we;
    logic [3:0]    lb_addr;
    logic [DW-1:0] lb_data;
    logic          lb_rd_bank, fetch_done, overrun, overrun_clr;

    video_line_fetch_arbiter #(
        .LINE_WIDTH(LW), .NUM_LINES(NL), .DATA_W(DW), .ADDR_W(AW),
        .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_valid(line_valid),
        .line_y(line_y), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
        .lb_data(lb_data), .lb_rd_bank(lb_rd_bank), .fetch_done(fetch_done),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Frame RAM model with two-cycle read latency
    logic [DW-1:0] ram [0:127];
    logic [DW-1:0] rp0, rp1;
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) rp0 <= ram[mem_addr];
        rp1 <= rp0;
    end
    assign mem_rdata = rp1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    typedef struct { logic bank; logic [2:0] x; logic [DW-1:0] data; } sb_t;
    sb_t        sb_q[$];
    logic [7:0] ev_q[$];
    int  n_rd = 0, n_wr = 0, n_lbwe = 0, n_fall = 0;
    int  last_rd_cyc = 0, last_we_cyc = 0, rise_cyc = 0;
    logic prev_done = 1'b1;
    logic m_bank = 1'b0;

    // Output monitor: RAM port events, scoreboard pops, fetch_done edges, port invariants
    always @(negedge clk) begin
        sb_t e;
        if (mem_rd) begin n_rd++; last_rd_cyc = cyc; ev_q.push_back({1'b0, mem_addr}); end
        if (mem_wr) begin n_wr++; ev_q.push_back({1'b1, mem_addr}); end
        if (lb_we) begin
            n_lbwe++;
            last_we_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL lb_unexp: lb_we with nothing expected, lb_addr=0x%0h", lb_addr);
            end else begin
                e = sb_q.pop_front();
                chk("lb_addr", {60'd0, lb_addr}, {60'd0, e.bank, e.x});
                chk("lb_data", {40'd0, lb_data}, {40'd0, e.data});
            end
        end
        if (prev_done && !fetch_done) n_fall++;
        if (!prev_done && fetch_done) rise_cyc = cyc;
        prev_done = fetch_done;
        if (!reset) begin
            chk("rd_wr_excl", {63'd0, mem_rd & mem_wr}, 64'd0);
            if (!mem_rd && !mem_wr) chk("idle_port_zero", {33'd0, mem_addr, mem_wdata}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [3:0] y);
        sb_t e;
        m_bank = ~m_bank;
        for (int x = 0; x < LW; x++) begin
            e.bank = ~m_bank;
            e.x    = 3'(x);
            e.data = ram[y*LW + x];
            sb_q.push_back(e);
        end
    endtask

    // Wait for fetch_done, releasing wr_req after its acknowledge; bounded
    task automatic wait_done();
        logic got_ack, done;
        got_ack = 1'b0;
        done    = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (wr_ack) got_ack = 1'b1;
            if (fetch_done) done = 1'b1;
            @(posedge clk);
            #1;
            if (got_ack) wr_req = 1'b0;
        end
        chk("done_timeout", {63'd0, done}, 64'd1);
        wr_req = 1'b0;
    endtask

    typedef struct packed {
        logic       valid;
        logic [3:0] y;
        logic       wr;
        logic [3:0] reads;
        logic [1:0] writes;
        logic       bank;
        logic [4:0] fill;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int r0, w0, f0, ls, bad;
        logic [7:0] exp_ev[$];
        r0 = n_rd; w0 = n_wr; f0 = n_fall;
        ev_q.delete();
        line_start = 1'b1; line_valid = v.valid; line_y = v.y;
        ls = cyc;
        if (v.valid) push_line(v.y);
        tick();
        line_start = 1'b0; line_valid = 1'b0;
        tick();
        if (v.wr) begin wr_addr = 7'h50; wr_data = 24'h123456 + 24'(v.y); wr_req = 1'b1; end
        wait_done();
        tick(); tick();
        chk("reads", n_rd - r0, {60'd0, v.reads});
        chk("writes", n_wr - w0, {62'd0, v.writes});
        chk("lb_rd_bank", {63'd0, lb_rd_bank}, {63'd0, v.bank});
        chk("fetch_done", {63'd0, fetch_done}, 64'd1);
        chk("done_falls", n_fall - f0, {63'd0, v.valid});
        chk("sb_empty", sb_q.size(), 64'd0);
        if (v.valid) begin
            for (int x = 0; x < LW; x++) begin
                if (v.wr && x == MB) exp_ev.push_back({1'b1, 7'h50});
                exp_ev.push_back({1'b0, 7'(v.y*LW + x)});
            end
            chk("done_lat", rise_cyc - last_rd_cyc, 64'd3);
            chk("fill_lat", last_we_cyc - ls, {59'd0, v.fill});
        end
        bad = (ev_q.size() != exp_ev.size()) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < exp_ev.size(); i++) if (ev_q[i] !== exp_ev[i]) bad++;
        chk("ev_seq", bad, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        int   ls, we0;
        tbl[0] = '{valid:1'b1, y:4'd3,  wr:1'b0, reads:4'd8, writes:2'd0, bank:1'b1, fill:5'd11};
        tbl[1] = '{valid:1'b1, y:4'd0,  wr:1'b1, reads:4'd8, writes:2'd1, bank:1'b0, fill:5'd12};
        tbl[2] = '{valid:1'b0, y:4'd5,  wr:1'b0, reads:4'd0, writes:2'd0, bank:1'b0, fill:5'd0};
        tbl[3] = '{valid:1'b1, y:4'd15, wr:1'b0, reads:4'd8, writes:2'd0, bank:1'b1, fill:5'd11};
        tbl[4] = '{valid:1'b1, y:4'd7,  wr:1'b1, reads:4'd8, writes:2'd1, bank:1'b0, fill:5'd12};

        for (int i = 0; i < 128; i++) ram[i] = {8'h5A, 8'(i), 8'(~i)};
        reset = 1'b1; line_start = 1'b0; line_valid = 1'b0; line_y = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; overrun_clr = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch_done", {63'd0, fetch_done}, 64'd1);
        chk("rst_bank", {63'd0, lb_rd_bank}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_strobes", {60'd0, mem_rd, mem_wr, lb_we, wr_ack}, 64'd0);
        reset = 1'b0;
        tick();

        // Table of line fetches
        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Idle write
        wr_addr = 7'h10; wr_data = 24'hABCDEF; wr_req = 1'b1;
        @(negedge clk);
        chk("iw_strobes", {61'd0, mem_wr, wr_ack, mem_rd}, 64'd6);
        chk("iw_addr", {57'd0, mem_addr}, 64'h10);
        chk("iw_data", {40'd0, mem_wdata}, 64'hABCDEF);
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        chk("iw_ack_pulse", {62'd0, wr_ack, mem_wr}, 64'd0);
        tick();

        // Overrun: second line start five cycles into a fetch
        line_start = 1'b1; line_valid = 1'b1; line_y = 4'd1;
        push_line(4'd1);
        we0 = n_lbwe;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        line_start = 1'b1; line_y = 4'd2;
        sb_q.delete();
        push_line(4'd2);
        @(negedge clk);
        chk("ovr_lbwe_gate", {63'd0, lb_we}, 64'd0);
        chk("ovr_rd_gate", {63'd0, mem_rd}, 64'd0);
        tick();
        line_start = 1'b0; line_valid = 1'b0;
        chk("ovr_aborted_we", n_lbwe - we0, 64'd1);
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        chk("ovr_refetch", {63'd0, fetch_done}, 64'd0);
        wait_done();
        tick(); tick();
        chk("ovr_sb_empty", sb_q.size(), 64'd0);
        chk("ovr_bank", {63'd0, lb_rd_bank}, 64'd0);
        overrun_clr = 1'b1;
        @(negedge clk);
        chk("ovr_hold", {63'd0, overrun}, 64'd1);
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", {63'd0, overrun}, 64'd0);

        // Asynchronous reset in the middle of a fetch
        line_start = 1'b1; line_valid = 1'b1; line_y = 4'd4;
        push_line(4'd4);
        tick();
        line_start = 1'b0; line_valid = 1'b0;
        repeat (3) tick();
        chk("pre_rst_active", {62'd0, mem_rd, lb_we}, 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_strobes", {62'd0, mem_rd, lb_we}, 64'd0);
        sb_q.delete();
        m_bank = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_done", {63'd0, fetch_done}, 64'd1);
        chk("post_rst_bank", {63'd0, lb_rd_bank}, 64'd0);
        chk("post_rst_ovr", {63'd0, overrun}, 64'd0);
        repeat (3) tick();
        chk("post_rst_idle", {61'd0, mem_rd, lb_we, fetch_done}, 64'd1);
        run_vec('{valid:1'b1, y:4'd6, wr:1'b0, reads:4'd8, writes:2'd0, bank:1'b1, fill:5'd11});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
